// File: rtl/hex_writer_pkg.sv
// Shared constants for the hex record loader: FSM encoding, sync byte, length decode.
package hex_writer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AHI,
    ST_ALO,
    ST_LEN,
    ST_DATA,
    ST_CHK
  } state_e;

  localparam logic [7:0] SYNC_BYTE = 8'h55;
  localparam int         LEN_W     = 9;

  // A length field of zero encodes a full 256-byte record.
  function automatic logic [LEN_W-1:0] rec_len(input logic [7:0] len);
    return (len == 8'd0) ? 9'd256 : {1'b0, len};
  endfunction

endpackage

// File: rtl/hex_timeout.sv
// Inter-byte idle counter; expired fires when LIMIT cycles pass without a clear.
module hex_timeout #(
  parameter int unsigned LIMIT = 1000000
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign expired = enable && !clear && (cnt_q == CW'(LIMIT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear)       cnt_d = '0;
    else if (enable) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/hex_writer.sv
// Serial record loader: parses SYNC/ADDR/LEN/DATA/CHK records and writes bytes to memory.
module hex_writer
  import hex_writer_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 14,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_en,
  output logic                  busy,
  output logic                  done,
  output logic                  err_chk,
  output logic                  err_tmo,
  input  logic                  err_clr
);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] ahi_q, ahi_d;
  logic [DATA_WIDTH-1:0] sum_q, sum_d, sum_next;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [LEN_W-1:0]      rem_q, rem_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  wr_en_q, wr_en_d;
  logic                  done_q, done_d;
  logic                  err_chk_q, err_chk_d;
  logic                  err_tmo_q, err_tmo_d;
  logic                  accept, chk_set, tmo_expired;

  // No back-pressure: ready follows reset directly so it drops the instant reset asserts.
  assign rx_ready = reset_n;
  assign accept   = rx_valid && rx_ready;
  assign sum_next = sum_q + rx_data;

  hex_timeout #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (accept || (state_q == ST_IDLE)),
    .enable  (state_q != ST_IDLE),
    .expired (tmo_expired)
  );

  always_comb begin
    state_d   = state_q;
    ahi_d     = ahi_q;
    sum_d     = sum_q;
    ptr_d     = ptr_q;
    rem_d     = rem_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_en_d   = 1'b0;
    done_d    = 1'b0;
    chk_set   = 1'b0;
    if (tmo_expired) begin
      state_d = ST_IDLE;
    end else if (accept) begin
      unique case (state_q)
        ST_IDLE: begin
          if (rx_data == DATA_WIDTH'(SYNC_BYTE)) begin
            state_d = ST_AHI;
            sum_d   = '0;
          end
        end
        ST_AHI: begin
          ahi_d   = rx_data;
          sum_d   = sum_next;
          state_d = ST_ALO;
        end
        ST_ALO: begin
          ptr_d   = ADDR_WIDTH'({ahi_q, rx_data});
          sum_d   = sum_next;
          state_d = ST_LEN;
        end
        ST_LEN: begin
          rem_d   = rec_len(rx_data[7:0]);
          sum_d   = sum_next;
          state_d = ST_DATA;
        end
        ST_DATA: begin
          wr_en_d   = 1'b1;
          wr_addr_d = ptr_q;
          wr_data_d = rx_data;
          ptr_d     = ptr_q + ADDR_WIDTH'(1);
          rem_d     = rem_q - LEN_W'(1);
          sum_d     = sum_next;
          if (rem_q == LEN_W'(1)) state_d = ST_CHK;
        end
        ST_CHK: begin
          state_d = ST_IDLE;
          if (sum_next == '0) done_d  = 1'b1;
          else                chk_set = 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase
    end
    // A new error event outranks a coincident clear.
    err_chk_d = chk_set     | (err_chk_q & ~err_clr);
    err_tmo_d = tmo_expired | (err_tmo_q & ~err_clr);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      ahi_q     <= '0;
      sum_q     <= '0;
      ptr_q     <= '0;
      rem_q     <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_en_q   <= 1'b0;
      done_q    <= 1'b0;
      err_chk_q <= 1'b0;
      err_tmo_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ahi_q     <= ahi_d;
      sum_q     <= sum_d;
      ptr_q     <= ptr_d;
      rem_q     <= rem_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_en_q   <= wr_en_d;
      done_q    <= done_d;
      err_chk_q <= err_chk_d;
      err_tmo_q <= err_tmo_d;
    end
  end

  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign wr_en   = wr_en_q;
  assign busy    = (state_q != ST_IDLE);
  assign done    = done_q;
  assign err_chk = err_chk_q;
  assign err_tmo = err_tmo_q;

endmodule
